// File: rtl/sdi_pkg.sv
// Shared types and helpers for the SDI receiver rate scan.
// Rate index, scan FSM states and one-hot conversion.
package sdi_pkg;

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    localparam logic [1:0] IDX_SD = 2'd0;
    localparam logic [1:0] IDX_HD = 2'd1;
    localparam logic [1:0] IDX_3G = 2'd2;

    // {3G, HD, SD} one-hot scan vector
    function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            IDX_HD:  oh = 3'b010;
            IDX_3G:  oh = 3'b100;
            default: oh = 3'b001;
        endcase
        return oh;
    endfunction

    // Scan order 3G -> HD -> SD -> 3G
    function automatic logic [1:0] idx_next(input logic [1:0] idx);
        logic [1:0] nx;
        case (idx)
            IDX_3G:  nx = IDX_HD;
            IDX_HD:  nx = IDX_SD;
            default: nx = IDX_3G;
        endcase
        return nx;
    endfunction

    // Manual rate code 3 is folded onto SD
    function automatic logic [1:0] idx_force(input logic [1:0] r);
        return (r == 2'd3) ? IDX_SD : r;
    endfunction

endpackage

// File: rtl/sdi_std_match.sv
// Detected-standard comparator.
// High when the received standard equals the scanned rate index.
module sdi_std_match
    import sdi_pkg::*;
(
    input  logic [1:0] idx,
    input  logic       tg_hdn,
    input  logic       hd_sdn,
    output logic       match
);

    // Decode the receiver flags against the current index
    always_comb begin
        match = 1'b0;
        case (idx)
            IDX_3G:  match = tg_hdn;
            IDX_HD:  match = !tg_hdn && hd_sdn;
            IDX_SD:  match = !tg_hdn && !hd_sdn;
            default: match = 1'b0;
        endcase
    end

endmodule

// File: rtl/sdi_rx_rate_scan.sv
// Multi-rate SDI receiver rate scan and lock supervisor.
// Scans 3G/HD/SD, confirms lock, supervises TRS errors, rescans.
module sdi_rx_rate_scan
    import sdi_pkg::*;
#(
    parameter int DWELL_CYCLES   = 1048576,
    parameter int CONFIRM_CYCLES = 65536,
    parameter int HOLD_CYCLES    = 262144,
    parameter int ERR_LIMIT      = 8,
    parameter int CNT_W          = 21
) (
    input  logic        rx_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        force_en,
    input  logic [1:0]  force_rate,
    input  logic        vid_active,
    input  logic        rx_tg_hdn,
    input  logic        rx_hd_sdn,
    input  logic        trs_out,
    input  logic        eav_error,
    input  logic        sav_error,
    output logic [2:0]  rx_rate,
    output logic        rate_locked,
    output logic        scan_busy,
    output logic        lock_pulse,
    output logic        unlock_pulse,
    output logic [15:0] trs_err_count
);

    localparam int ERR_W = $clog2(ERR_LIMIT + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_LAST     = ERR_W'(ERR_LIMIT - 1);

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [15:0]      tec_q, tec_d;
    logic             force_q, force_d;
    logic [2:0]       rate_q, rate_d;
    logic             locked_q, locked_d;
    logic             busy_q, busy_d;
    logic             lock_p_q, lock_p_d;
    logic             unlock_p_q, unlock_p_d;
    logic             std_match;
    logic             qual;
    logic             err_hit;

    sdi_std_match u_match (
        .idx    (idx_q),
        .tg_hdn (rx_tg_hdn),
        .hd_sdn (rx_hd_sdn),
        .match  (std_match)
    );

    assign qual    = vid_active && std_match;
    assign err_hit = trs_out && (eav_error || sav_error);

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        tec_d   = tec_q;
        force_d = force_en;
        if (!enable) begin
            state_d = ST_SCAN;
            cnt_d   = '0;
            err_d   = '0;
        end else if (force_q && !force_en) begin
            state_d = ST_SCAN;
            cnt_d   = '0;
            err_d   = '0;
        end else begin
            unique case (state_q)
                ST_SCAN: begin
                    if (qual) begin
                        state_d = ST_CONFIRM;
                        cnt_d   = '0;
                    end else if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (!force_en) idx_d = idx_next(idx_q);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_CONFIRM: begin
                    if (!qual) begin
                        state_d = ST_SCAN;
                        cnt_d   = '0;
                    end else if (cnt_q == CONFIRM_LAST) begin
                        state_d = ST_LOCKED;
                        cnt_d   = '0;
                        err_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (err_hit) begin
                        err_d = err_q + ERR_W'(1);
                        if (tec_q != 16'hFFFF) tec_d = tec_q + 16'd1;
                    end else if (trs_out) begin
                        err_d = '0;
                    end
                    if (!qual || (err_hit && err_q == ERR_LAST)) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
                ST_HOLD: begin
                    if (qual) begin
                        state_d = ST_LOCKED;
                        cnt_d   = '0;
                        err_d   = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = ST_SCAN;
                        cnt_d   = '0;
                        if (!force_en) idx_d = idx_next(idx_q);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end
            endcase
            if (force_en) idx_d = idx_force(force_rate);
        end
        rate_d     = idx_onehot(idx_d);
        locked_d   = (state_d == ST_LOCKED);
        busy_d     = (state_d == ST_SCAN) || (state_d == ST_CONFIRM);
        lock_p_d   = (state_d == ST_LOCKED) && (state_q != ST_LOCKED);
        unlock_p_d = (state_q == ST_LOCKED) && (state_d == ST_HOLD);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            state_q    <= ST_SCAN;
            idx_q      <= IDX_3G;
            cnt_q      <= '0;
            err_q      <= '0;
            tec_q      <= '0;
            force_q    <= 1'b0;
            rate_q     <= 3'b100;
            locked_q   <= 1'b0;
            busy_q     <= 1'b1;
            lock_p_q   <= 1'b0;
            unlock_p_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            tec_q      <= tec_d;
            force_q    <= force_d;
            rate_q     <= rate_d;
            locked_q   <= locked_d;
            busy_q     <= busy_d;
            lock_p_q   <= lock_p_d;
            unlock_p_q <= unlock_p_d;
        end
    end

    assign rx_rate       = rate_q;
    assign rate_locked   = locked_q;
    assign scan_busy     = busy_q;
    assign lock_pulse    = lock_p_q;
    assign unlock_pulse  = unlock_p_q;
    assign trs_err_count = tec_q;

endmodule

// File: tb/tb_sdi_rx_rate_scan.sv
// Bench for sdi_rx_rate_scan: directed plus random stimulus,
// expectations queued from a behavioural model, compared by a monitor.
module tb_sdi_rx_rate_scan;

    localparam int DW = 16;
    localparam int CF = 8;
    localparam int HL = 12;
    localparam int EL = 3;

    localparam int S_SCAN = 0;
    localparam int S_CONF = 1;
    localparam int S_LOCK = 2;
    localparam int S_HOLD = 3;

    logic        clk = 1'b0;
    logic        rst, enable, force_en;
    logic [1:0]  force_rate;
    logic        vid_active, rx_tg_hdn, rx_hd_sdn;
    logic        trs_out, eav_error, sav_error;
    logic [2:0]  rx_rate;
    logic        rate_locked, scan_busy, lock_pulse, unlock_pulse;
    logic [15:0] trs_err_count;

    typedef struct packed {
        logic       rst;
        logic       enable;
        logic       force_en;
        logic [1:0] force_rate;
        logic       vid;
        logic       tg;
        logic       hd;
        logic       trs;
        logic       eav;
        logic       sav;
    } stim_t;

    typedef struct packed {
        logic [2:0]  rate;
        logic        locked;
        logic        busy;
        logic        lp;
        logic        up;
        logic [15:0] tec;
    } exp_t;

    exp_t  expq[$];
    stim_t cur;
    int    checks = 0;
    int    failures = 0;

    int m_st = S_SCAN;
    int m_rate = 2;
    int m_cnt = 0;
    int m_err = 0;
    int m_tec = 0;
    bit m_fq = 1'b0;

    always #5 clk = ~clk;

    sdi_rx_rate_scan #(
        .DWELL_CYCLES   (DW),
        .CONFIRM_CYCLES (CF),
        .HOLD_CYCLES    (HL),
        .ERR_LIMIT      (EL),
        .CNT_W          (8)
    ) dut (
        .rx_clk        (clk),
        .rst           (rst),
        .enable        (enable),
        .force_en      (force_en),
        .force_rate    (force_rate),
        .vid_active    (vid_active),
        .rx_tg_hdn     (rx_tg_hdn),
        .rx_hd_sdn     (rx_hd_sdn),
        .trs_out       (trs_out),
        .eav_error     (eav_error),
        .sav_error     (sav_error),
        .rx_rate       (rx_rate),
        .rate_locked   (rate_locked),
        .scan_busy     (scan_busy),
        .lock_pulse    (lock_pulse),
        .unlock_pulse  (unlock_pulse),
        .trs_err_count (trs_err_count)
    );

    // Behavioural model: rate 2=3G,1=HD,0=SD; counters count elapsed cycles
    task automatic model_step(input stim_t s);
        int  det;
        int  prev;
        bit  match;
        bit  ehit;
        exp_t e;
        prev  = m_st;
        det   = s.tg ? 2 : (s.hd ? 1 : 0);
        match = s.vid && (det == m_rate);
        ehit  = s.trs && (s.eav || s.sav);
        if (s.rst) begin
            m_st = S_SCAN; m_rate = 2; m_cnt = 0;
            m_err = 0; m_tec = 0; m_fq = 1'b0;
            prev = S_SCAN;
        end else if (!s.enable) begin
            m_st = S_SCAN; m_cnt = 0; m_err = 0;
            m_fq = s.force_en;
        end else begin
            if (m_fq && !s.force_en) begin
                m_st = S_SCAN; m_cnt = 0; m_err = 0;
            end else begin
                case (m_st)
                    S_SCAN: begin
                        if (match) begin
                            m_st = S_CONF; m_cnt = 0;
                        end else begin
                            m_cnt++;
                            if (m_cnt == DW) begin
                                m_cnt = 0;
                                if (!s.force_en) m_rate = (m_rate + 2) % 3;
                            end
                        end
                    end
                    S_CONF: begin
                        if (!match) begin
                            m_st = S_SCAN; m_cnt = 0;
                        end else begin
                            m_cnt++;
                            if (m_cnt == CF) begin
                                m_st = S_LOCK; m_cnt = 0; m_err = 0;
                            end
                        end
                    end
                    S_LOCK: begin
                        if (ehit) begin
                            m_err++;
                            if (m_tec < 65535) m_tec++;
                        end else if (s.trs) begin
                            m_err = 0;
                        end
                        if (!match || m_err >= EL) begin
                            m_st = S_HOLD; m_cnt = 0;
                        end
                    end
                    default: begin
                        if (match) begin
                            m_st = S_LOCK; m_cnt = 0; m_err = 0;
                        end else begin
                            m_cnt++;
                            if (m_cnt == HL) begin
                                m_st = S_SCAN; m_cnt = 0;
                                if (!s.force_en) m_rate = (m_rate + 2) % 3;
                            end
                        end
                    end
                endcase
            end
            if (s.force_en) m_rate = (s.force_rate == 2'd3) ? 0 : int'(s.force_rate);
            m_fq = s.force_en;
        end
        e.rate   = 3'(1 << m_rate);
        e.locked = (m_st == S_LOCK);
        e.busy   = (m_st == S_SCAN) || (m_st == S_CONF);
        e.lp     = (m_st == S_LOCK) && (prev != S_LOCK);
        e.up     = (prev == S_LOCK) && (m_st == S_HOLD);
        e.tec    = 16'(m_tec);
        expq.push_back(e);
    endtask

    task automatic step(input stim_t s);
        @(negedge clk);
        rst        = s.rst;
        enable     = s.enable;
        force_en   = s.force_en;
        force_rate = s.force_rate;
        vid_active = s.vid;
        rx_tg_hdn  = s.tg;
        rx_hd_sdn  = s.hd;
        trs_out    = s.trs;
        eav_error  = s.eav;
        sav_error  = s.sav;
        model_step(s);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(cur);
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, got, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle, compare one entry per edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("rx_rate", int'(rx_rate), int'(e.rate));
                chk("rate_locked", int'(rate_locked), int'(e.locked));
                chk("scan_busy", int'(scan_busy), int'(e.busy));
                chk("lock_pulse", int'(lock_pulse), int'(e.lp));
                chk("unlock_pulse", int'(unlock_pulse), int'(e.up));
                chk("trs_err_count", int'(trs_err_count), int'(e.tec));
            end
        end
    end

    initial begin
        int k;
        int len;
        int std;
        cur = '0;
        cur.rst = 1'b1;
        cur.enable = 1'b1;
        step(cur);
        run(2);
        cur.rst = 1'b0;
        // no video: rate walks 3G -> HD -> SD -> 3G
        run(60);
        k = 0;
        while (m_rate != 1 && k < 64) begin
            step(cur);
            k++;
        end
        // HD video on the HD rate: confirm then lock
        cur.vid = 1'b1; cur.tg = 1'b0; cur.hd = 1'b1;
        run(20);
        // three consecutive erroneous TRS
        for (int i = 0; i < 3; i++) begin
            cur.trs = 1'b1; cur.eav = 1'b1;
            step(cur);
            cur.trs = 1'b0; cur.eav = 1'b0;
            run(2);
        end
        cur.vid = 1'b0;
        run(20);
        // SD video on the SD rate, then a short dropout
        cur.vid = 1'b1; cur.hd = 1'b0;
        run(15);
        cur.vid = 1'b0;
        run(5);
        cur.vid = 1'b1;
        run(5);
        // reset while locked
        cur.rst = 1'b1;
        step(cur);
        cur.rst = 1'b0; cur.vid = 1'b0;
        run(3);
        // forced 3G with no video
        cur.force_en = 1'b1; cur.force_rate = 2'd2;
        run(60);
        cur.force_rate = 2'd1; cur.vid = 1'b1; cur.hd = 1'b1;
        run(20);
        cur.force_en = 1'b0;
        run(5);
        cur.enable = 1'b0;
        run(5);
        cur.enable = 1'b1;
        run(30);
        // randomized segments
        for (int sgi = 0; sgi < 120; sgi++) begin
            len = int'($urandom_range(1, 90));
            std = int'($urandom_range(0, 2));
            cur.vid = ($urandom_range(0, 3) != 0);
            cur.tg = (std == 2);
            cur.hd = (std == 2) ? 1'($urandom_range(0, 1)) : (std == 1);
            cur.force_en = ($urandom_range(0, 9) == 0);
            cur.force_rate = 2'($urandom_range(0, 3));
            cur.enable = ($urandom_range(0, 19) != 0);
            for (int i = 0; i < len; i++) begin
                cur.rst = ($urandom_range(0, 499) == 0);
                cur.trs = ($urandom_range(0, 5) == 0);
                cur.eav = cur.trs && ($urandom_range(0, 2) == 0);
                cur.sav = cur.trs && ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 59) == 0) cur.vid = !cur.vid;
                step(cur);
            end
        end
        cur = '0;
        cur.enable = 1'b1;
        run(2);
        k = 0;
        while (expq.size() != 0 && k < 10) begin
            @(posedge clk);
            k++;
        end
        #2;
        chk("queue_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdi_rx_rate_scan.md
# sdi_rx_rate_scan

Controls the rate scan of the multi-rate SDI receiver. The block drives the receiver's `rx_rate` scan vector through 3G, HD and SD in turn. It confirms lock from `vid_active` and the detected-standard flags, then supervises the locked link through TRS error reports. When lock is lost it rescans. It sits between the SDI receiver core and the system control logic, in the `rx_clk` domain.

## Interface
Parameters:
- `DWELL_CYCLES`, default 1048576: cycles spent on one rate before advancing while unlocked.
- `CONFIRM_CYCLES`, default 65536: cycles `vid_active` plus a matching standard must persist before lock is declared.
- `HOLD_CYCLES`, default 262144: grace period after lock loss before rescanning.
- `ERR_LIMIT`, default 8: consecutive erroneous TRS that declare lock loss.
- `CNT_W`, default 21: width of the dwell, confirm and hold counters; must hold the largest cycle parameter.

Ports:
- `rx_clk`  in  1  sole clock. Reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `enable`  in  1  0 means the block is held in SCAN with counters cleared and `rx_rate` frozen.
- `force_en`  in  1  manual rate mode.
- `force_rate`  in  2  0=SD, 1=HD, 2=3G; the value 3 is treated as SD.
- `vid_active`  in  1  receiver locked to valid video.
- `rx_tg_hdn`  in  1  1 means a 3G standard is being received.
- `rx_hd_sdn`  in  1  1 means HD, 0 means SD; only meaningful when `rx_tg_hdn`=0.
- `trs_out`  in  1  TRS word present (single-cycle per TRS).
- `eav_error`, `sav_error`  in  1 each  TRS error flags, qualified by `trs_out`.
- `rx_rate`  out  3  {3G, HD, SD} one-hot scan enable to the receiver.
- `rate_locked`  out  1  high in LOCKED state.
- `scan_busy`  out  1  high in SCAN or CONFIRM.
- `lock_pulse`  out  1  one-cycle strobe on each entry to LOCKED.
- `unlock_pulse`  out  1  one-cycle strobe on each LOCKED→HOLD transition.
- `trs_err_count`  out  16  saturating count of erroneous TRS seen while LOCKED.

## Operation
- The rate index cycles 3G → HD → SD → 3G. `rx_rate` is the one-hot form of the current index and is registered.
- A standard "matches" when the detected standard equals the current index: 3G is `rx_tg_hdn`=1; HD is `rx_tg_hdn`=0 and `rx_hd_sdn`=1; SD is `rx_tg_hdn`=0 and `rx_hd_sdn`=0.
- SCAN state:
  - The dwell counter increments each cycle.
  - When `vid_active` is high and the standard matches, go to CONFIRM and clear the counter.
  - When the counter reaches `DWELL_CYCLES`-1, advance the index and clear the counter.
- CONFIRM state:
  - Each cycle with `vid_active` high and a matching standard, the counter increments.
  - If either condition fails, return to SCAN at the same index with the dwell restarted.
  - When the counter reaches `CONFIRM_CYCLES`-1, go to LOCKED and assert `lock_pulse`.
- LOCKED state:
  - A consecutive-error counter increments on `trs_out` with `eav_error` or `sav_error` set.
  - It clears on `trs_out` with neither error flag set.
  - Go to HOLD when `vid_active` falls, when the standard mismatches, or when the consecutive-error counter reaches `ERR_LIMIT`. Assert `unlock_pulse` on this transition.
  - `trs_err_count` increments by 1 per erroneous TRS (both flags in one cycle still count 1). It saturates at 0xFFFF and clears only on reset.
- HOLD state:
  - The counter runs.
  - If `vid_active` is high and the standard matches, return to LOCKED with the error counter cleared and `lock_pulse` asserted.
  - When the counter reaches `HOLD_CYCLES`-1, go to SCAN with the index advanced.
- Force mode (`force_en`=1):
  - The index is taken from `force_rate` every cycle.
  - Dwell expiry and HOLD expiry never advance the index; expiry only restarts the counter, or for HOLD returns to SCAN at the same index.
  - Deasserting `force_en` resumes normal scanning from the current index with the counters cleared.
- `enable`=0 overrides everything except reset. It forces SCAN with counters cleared; it does not clear `trs_err_count`.
- Reset values:
  - State is SCAN and the index is 3G, so `rx_rate`=3'b100.
  - `rate_locked`=0, `scan_busy`=1, both pulses 0.
  - `trs_err_count`=0 and all counters 0.
- Reset mid-lock: on the next edge the block is back in SCAN at 3G with no `unlock_pulse`.

## Timing
- All outputs are registered.
- A decision made from inputs sampled at edge N is visible on the outputs after edge N.
- The `rx_rate` change takes effect on the same edge as the dwell counter clears.
- CONFIRM to LOCKED takes exactly `CONFIRM_CYCLES` qualifying cycles counted from the SCAN→CONFIRM edge.
- Simultaneous events:
  - In SCAN, a match in the dwell-expiry cycle wins: go to CONFIRM, no advance.
  - In HOLD, reacquisition in the expiry cycle wins.
  - In LOCKED, `vid_active` loss and the error limit in the same cycle give a single `unlock_pulse`.

## Structure
- Shared package `sdi_pkg`: the state enum {SCAN, CONFIRM, LOCKED, HOLD}, the rate index constants (SD=0, HD=1, 3G=2), and a one-hot conversion function.
- One natural sub-module, `sdi_std_match`: combinational match logic from index, `rx_tg_hdn` and `rx_hd_sdn`.
- Everything else lives in a single FSM module.

## Test plan
Use DWELL=16, CONFIRM=8, HOLD=12, ERR_LIMIT=3.
- No video input → `rx_rate` steps 100 → 010 → 001 → 100, one step every 16 cycles; `rate_locked` stays 0.
- Present HD video (`vid_active`=1, `rx_hd_sdn`=1) while the HD rate is active → `lock_pulse` fires after 8 cycles and `rate_locked`=1 with `rx_rate`=010.
- While locked, 3 consecutive TRS with `eav_error` → `unlock_pulse` fires and `trs_err_count`=3; no recovery → after 12 cycles the block is in SCAN with `rx_rate`=001.
- While locked, drop `vid_active` for 5 cycles then restore it → back to LOCKED with no rate change and a second `lock_pulse`.
- Set `force_en`=1 with `force_rate`=2 and no video → `rx_rate` stays at 100 indefinitely.
- Assert `rst` mid-lock → next cycle `rx_rate`=100, `rate_locked`=0 and `trs_err_count`=0.
